// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the systolic processing element:
//   - datapath widths (ACC_W, DATA_W)
//   - operand format codes for the DATA_TYPE parameter
//   - lane_count(dt) : number of packed lanes in a 32-bit operand word
//   - is_signed(dt)  : whether lanes are two's complement
// The reserved codes 110/111 behave as int32 in both helper functions.
// ---------------------------------------------------------------------------
package pe_pkg;

   localparam int ACC_W  = 64;
   localparam int DATA_W = 32;

   localparam logic [2:0] DT_UINT8  = 3'b000;
   localparam logic [2:0] DT_UINT16 = 3'b001;
   localparam logic [2:0] DT_UINT32 = 3'b010;
   localparam logic [2:0] DT_INT8   = 3'b011;
   localparam logic [2:0] DT_INT16  = 3'b100;
   localparam logic [2:0] DT_INT32  = 3'b101;

   function automatic int lane_count(input logic [2:0] dt);
      case (dt)
         DT_UINT8,  DT_INT8:  return 4;
         DT_UINT16, DT_INT16: return 2;
         default:             return 1;
      endcase
   endfunction

   function automatic logic is_signed(input logic [2:0] dt);
      return (dt >= DT_INT8);
   endfunction

endpackage

// File: rtl/pe_lane_mul.sv
// ---------------------------------------------------------------------------
// pe_lane_mul
// One multiplier slice of the PE. Multiplies two W-bit lane operands at full
// 2W-bit precision and extends the product to ACC_W bits (sign-extension when
// IS_SIGNED, zero-extension otherwise). Unused lanes are fed zero operands by
// the parent, so their contribution is a constant zero.
// Ports:
//   a, b  in   W      lane operands
//   prod  out  ACC_W  extended lane product
// ---------------------------------------------------------------------------
module pe_lane_mul
   import pe_pkg::*;
#(
   parameter int W         = 8,
   parameter bit IS_SIGNED = 1'b1
) (
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic [ACC_W-1:0] prod
);

   logic [2*W-1:0] a_ext;
   logic [2*W-1:0] b_ext;
   logic [2*W-1:0] p_full;

   // Extending both operands to 2W first makes the modulo-2^(2W) product
   // exact for both signed and unsigned interpretations.
   if (IS_SIGNED) begin : g_signed
      assign a_ext = {{W{a[W-1]}}, a};
      assign b_ext = {{W{b[W-1]}}, b};
   end else begin : g_unsigned
      assign a_ext = {{W{1'b0}}, a};
      assign b_ext = {{W{1'b0}}, b};
   end

   assign p_full = a_ext * b_ext;

   if (2*W == ACC_W) begin : g_no_ext
      assign prod = p_full;
   end else if (IS_SIGNED) begin : g_sext
      assign prod = {{(ACC_W-2*W){p_full[2*W-1]}}, p_full};
   end else begin : g_zext
      assign prod = {{(ACC_W-2*W){1'b0}}, p_full};
   end

endmodule

// File: rtl/systolic_pe.sv
// ---------------------------------------------------------------------------
// systolic_pe
// Processing element of an output-stationary systolic matrix-multiply array.
// Each cycle the packed row/column operands are multiplied lane by lane, the
// lane products summed (stage 1, registered) and added into a 64-bit
// accumulator (stage 2). Operands are forwarded east/south through one
// register each so that neighbouring PEs see skewed data.
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset, clears every register
//   row_in     in   32  packed row operand, lane 0 in the low bits
//   col_in     in   32  packed column operand, same packing
//   row_out    out  32  row_in delayed one cycle
//   col_out    out  32  col_in delayed one cycle
//   pe_result  out  65  {sticky overflow flag, accumulator[63:0]}
// ---------------------------------------------------------------------------
module systolic_pe
   import pe_pkg::*;
#(
   parameter logic [2:0] DATA_TYPE = 3'b011
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] row_in,
   input  logic [DATA_W-1:0] col_in,
   output logic [DATA_W-1:0] row_out,
   output logic [DATA_W-1:0] col_out,
   output logic [ACC_W:0]    pe_result
);

   // Reserved codes fold onto int32.
   localparam logic [2:0] DT    = (DATA_TYPE > DT_INT32) ? DT_INT32 : DATA_TYPE;
   localparam int         LANES = lane_count(DT);
   localparam int         LW    = DATA_W / LANES;
   localparam bit         SGN   = is_signed(DT);

   logic [ACC_W-1:0] lane_prod [4];
   logic [ACC_W-1:0] sum_lo;
   logic [ACC_W-1:0] sum_hi;
   logic [ACC_W-1:0] prod_sum;

   logic [ACC_W-1:0] prod_q;
   logic [ACC_W-1:0] acc_q;
   logic             ovf_q;

   logic [ACC_W:0]   acc_sum;
   logic             wrap_unsigned;
   logic             wrap_signed;
   logic             wrap;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      if (i < LANES) begin : g_active
         pe_lane_mul #(.W(LW), .IS_SIGNED(SGN)) u_mul (
            .a    (row_in[i*LW +: LW]),
            .b    (col_in[i*LW +: LW]),
            .prod (lane_prod[i])
         );
      end else begin : g_idle
         pe_lane_mul #(.W(LW), .IS_SIGNED(SGN)) u_mul (
            .a    ('0),
            .b    ('0),
            .prod (lane_prod[i])
         );
      end
   end

   // Two-level adder tree; wraps modulo 2^64 like the accumulator.
   assign sum_lo   = lane_prod[0] + lane_prod[1];
   assign sum_hi   = lane_prod[2] + lane_prod[3];
   assign prod_sum = sum_lo + sum_hi;

   // Wrap detection for the stage-2 add: carry out for unsigned formats,
   // same-sign operands giving a different-sign result for signed formats.
   assign acc_sum       = {1'b0, acc_q} + {1'b0, prod_q};
   assign wrap_unsigned = acc_sum[ACC_W];
   assign wrap_signed   = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) &&
                          (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
   assign wrap          = SGN ? wrap_signed : wrap_unsigned;

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_out <= '0;
         col_out <= '0;
         prod_q  <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         row_out <= row_in;
         col_out <= col_in;
         prod_q  <= prod_sum;
         acc_q   <= acc_sum[ACC_W-1:0];
         ovf_q   <= ovf_q | wrap;
      end
   end

   assign pe_result = {ovf_q, acc_q};

endmodule

// File: tb/tb_systolic_pe.sv
// ---------------------------------------------------------------------------
// tb_systolic_pe
// One DUT per operand format (including a reserved code) shares the same
// clock, reset and operand stimulus. A lane-arithmetic model tracks the
// expected accumulator and flag for every format; a negedge process compares
// all outputs each cycle, and directed phases pin the model with literals.
// ---------------------------------------------------------------------------
module tb_systolic_pe;

   localparam int NDUT = 7;
   localparam logic [2:0] DT_LIST [NDUT] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                             3'b100, 3'b111, 3'b101};
   localparam int I_UINT32 = 2;
   localparam int I_INT8   = 3;
   localparam int I_RSV    = 5;
   localparam int I_INT32  = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] row = 32'hDEAD_BEEF;
   logic [31:0] col = 32'h1234_5678;

   logic [31:0] ro  [NDUT];
   logic [31:0] co  [NDUT];
   logic [64:0] res [NDUT];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      systolic_pe #(.DATA_TYPE(DT_LIST[g])) u_dut (
         .clk       (clk),
         .rst       (rst),
         .row_in    (row),
         .col_in    (col),
         .row_out   (ro[g]),
         .col_out   (co[g]),
         .pe_result (res[g])
      );
   end

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Sum of lane products, each lane interpreted per the format.
   function automatic logic [63:0] model_p(input logic [2:0] dt, input logic [31:0] r,
                                           input logic [31:0] c);
      int          w;
      bit          sg;
      logic [63:0] mask, a, b, s;
      case (dt)
         3'd0, 3'd3: w = 8;
         3'd1, 3'd4: w = 16;
         default:    w = 32;
      endcase
      sg   = (dt >= 3'd3);
      mask = (64'd1 << w) - 64'd1;
      s    = '0;
      for (int l = 0; l < 32 / w; l++) begin
         a = (64'(r) >> (l * w)) & mask;
         b = (64'(c) >> (l * w)) & mask;
         if (sg && a[w-1]) a = a | ~mask;
         if (sg && b[w-1]) b = b | ~mask;
         s = s + a * b;
      end
      return s;
   endfunction

   // True if acc + p is not representable in 64 bits for the format.
   function automatic logic model_wrap(input logic [2:0] dt, input logic [63:0] acc,
                                       input logic [63:0] p);
      logic [65:0] ex;
      if (dt >= 3'd3) begin
         ex = {{2{acc[63]}}, acc} + {{2{p[63]}}, p};
         return !(ex[65:63] == 3'b000 || ex[65:63] == 3'b111);
      end
      ex = {2'b00, acc} + {2'b00, p};
      return ex[64];
   endfunction

   logic [63:0] m_p    [NDUT] = '{default: '0};
   logic [63:0] m_acc  [NDUT] = '{default: '0};
   logic        m_flag [NDUT] = '{default: 1'b0};
   logic [31:0] m_row  = '0;
   logic [31:0] m_col  = '0;

   always @(posedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         if (rst) begin
            m_p[i]    <= '0;
            m_acc[i]  <= '0;
            m_flag[i] <= 1'b0;
         end else begin
            m_p[i]    <= model_p(DT_LIST[i], row, col);
            m_acc[i]  <= m_acc[i] + m_p[i];
            m_flag[i] <= m_flag[i] | model_wrap(DT_LIST[i], m_acc[i], m_p[i]);
         end
      end
      m_row <= rst ? 32'h0 : row;
      m_col <= rst ? 32'h0 : col;
   end

   always @(negedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("cyc res[%0d]", i), res[i], {m_flag[i], m_acc[i]});
         check($sformatf("cyc row_out[%0d]", i), 65'(ro[i]), 65'(m_row));
         check($sformatf("cyc col_out[%0d]", i), 65'(co[i]), 65'(m_col));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [31:0] win_row [7] = '{32'h2, 32'hA, 32'h7, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h0};
   logic [31:0] win_col [7] = '{32'h3, 32'hB, 32'h8, 32'h6, 32'hF, 32'hFFFF_FFFF, 32'h0};
   logic [63:0] win_acc [6] = '{64'd120, 64'd2320, 64'd3440, 64'd4040, 64'd4040, 64'd4120};
   logic [31:0] corner  [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                32'h8080_8080, 32'h7F7F_7F7F, 32'h0000_0000};

   initial begin
      // Reset with nonzero operands held on the inputs.
      step(4);
      check("rst res", res[I_INT8], 65'h0);
      check("rst row_out", 65'(ro[I_INT8]), 65'h0);
      check("rst col_out", 65'(co[I_INT8]), 65'h0);

      // Chained int8 windows; cumulative total is visible one edge into the
      // following window.
      rst = 1'b0;
      for (int w = 0; w < 7; w++) begin
         row = win_row[w];
         col = win_col[w];
         step(1);
         check($sformatf("fwd row w%0d", w), 65'(ro[I_INT8]), 65'(win_row[w]));
         check($sformatf("fwd col w%0d", w), 65'(co[I_INT8]), 65'(win_col[w]));
         if (w > 0) check($sformatf("int8 acc w%0d", w - 1), res[I_INT8], {1'b0, win_acc[w-1]});
         step(19);
      end

      // uint32 max square: second add carries out of bit 63.
      rst = 1'b1;
      step(1);
      check("u32 rst", res[I_UINT32], 65'h0);
      rst = 1'b0;
      row = 32'hFFFF_FFFF;
      col = 32'hFFFF_FFFF;
      step(2);
      check("u32 add1", res[I_UINT32], {1'b0, 64'hFFFF_FFFE_0000_0001});
      step(1);
      check("u32 add2", res[I_UINT32], {1'b1, 64'hFFFF_FFFC_0000_0002});
      step(3);
      check("u32 sticky", 65'(res[I_UINT32][64]), 65'h1);

      // int32 (and reserved code) -2^31 squared: second add overflows sign.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      row = 32'h8000_0000;
      col = 32'h8000_0000;
      step(2);
      check("i32 add1", res[I_INT32], {1'b0, 64'h4000_0000_0000_0000});
      check("rsv add1", res[I_RSV], {1'b0, 64'h4000_0000_0000_0000});
      step(1);
      check("i32 add2", res[I_INT32], {1'b1, 64'h8000_0000_0000_0000});
      check("rsv add2", res[I_RSV], {1'b1, 64'h8000_0000_0000_0000});
      rst = 1'b1;
      step(1);
      check("i32 midrst res", res[I_INT32], 65'h0);
      check("i32 midrst row", 65'(ro[I_INT32]), 65'h0);
      check("i32 midrst col", 65'(co[I_INT32]), 65'h0);
      rst = 1'b0;

      // Randomized windows with corner operands and occasional resets.
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            row = corner[$urandom_range(0, 5)];
            col = corner[$urandom_range(0, 5)];
         end else begin
            row = $urandom;
            col = $urandom;
         end
         rst = ($urandom_range(0, 9) == 0);
         step($urandom_range(1, 8));
      end
      rst = 1'b0;
      row = '0;
      col = '0;
      step(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
